// File: rtl/svc_rv_dbus_mon.sv
// Data-bus monitor: turns dmem read/write traffic into one registered
// bus event per cycle, with pending-read and write queues.
module svc_rv_dbus_mon #(
  parameter int RD_LAT = 0,
  parameter int QDEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_ren,
  input  logic [31:0] dmem_raddr,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_we,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        bus_valid,
  output logic        bus_insn,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_rmask,
  output logic [3:0]  bus_wmask,
  output logic [31:0] bus_rdata,
  output logic [31:0] bus_wdata,
  output logic        err_overflow,
  output logic        err_protocol
);
  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  logic        rd_done;
  logic [31:0] rd_addr;
  logic        rd_ovf;
  logic        rd_proto;

  generate
    if (RD_LAT == 0) begin : g_sram
      assign rd_done  = dmem_ren && dmem_rvalid;
      assign rd_addr  = dmem_raddr;
      assign rd_ovf   = 1'b0;
      assign rd_proto = 1'b0;
    end else begin : g_bram
      logic [31:0]   pq [QDEPTH];
      logic [PW-1:0] pq_wp;
      logic [PW-1:0] pq_rp;
      logic          pq_empty;
      logic          pq_full;
      logic          pq_pop;
      logic          pq_push;

      assign pq_empty = pq_wp == pq_rp;
      assign pq_full  = (pq_wp[AW] != pq_rp[AW]) &&
                        (pq_wp[AW-1:0] == pq_rp[AW-1:0]);
      assign pq_pop   = dmem_rvalid && !pq_empty;
      assign pq_push  = dmem_ren && (!pq_full || pq_pop);

      assign rd_done  = pq_pop;
      assign rd_addr  = pq[pq_rp[AW-1:0]];
      assign rd_ovf   = dmem_ren && pq_full && !pq_pop;
      assign rd_proto = dmem_rvalid && pq_empty;

      always_ff @(posedge clock) begin
        if (reset) begin
          pq_wp <= '0;
          pq_rp <= '0;
        end else begin
          if (pq_push) pq_wp <= pq_wp + PW'(1);
          if (pq_pop)  pq_rp <= pq_rp + PW'(1);
        end
      end

      always_ff @(posedge clock) begin
        if (!reset && pq_push) pq[pq_wp[AW-1:0]] <= dmem_raddr;
      end
    end
  endgenerate

  logic [31:0]   wq_addr [QDEPTH];
  logic [31:0]   wq_data [QDEPTH];
  logic [3:0]    wq_strb [QDEPTH];
  logic [PW-1:0] wq_wp;
  logic [PW-1:0] wq_rp;
  logic          wq_empty;
  logic          wq_full;
  logic          wq_pop;
  logic          wq_push;
  logic          wr_byp;
  logic          wr_ovf;

  assign wq_empty = wq_wp == wq_rp;
  assign wq_full  = (wq_wp[AW] != wq_rp[AW]) &&
                    (wq_wp[AW-1:0] == wq_rp[AW-1:0]);
  assign wq_pop   = !rd_done && !wq_empty;
  assign wr_byp   = !rd_done && wq_empty && dmem_we;
  assign wq_push  = dmem_we && !wr_byp && (!wq_full || wq_pop);
  assign wr_ovf   = dmem_we && !wr_byp && wq_full && !wq_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      wq_wp <= '0;
      wq_rp <= '0;
    end else begin
      if (wq_push) wq_wp <= wq_wp + PW'(1);
      if (wq_pop)  wq_rp <= wq_rp + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wq_push) begin
      wq_addr[wq_wp[AW-1:0]] <= dmem_waddr;
      wq_data[wq_wp[AW-1:0]] <= dmem_wdata;
      wq_strb[wq_wp[AW-1:0]] <= dmem_wstrb;
    end
  end

  // Read completion wins, then oldest queued write, then bypass.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_valid    <= 1'b0;
      bus_addr     <= '0;
      bus_rmask    <= '0;
      bus_wmask    <= '0;
      bus_rdata    <= '0;
      bus_wdata    <= '0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      bus_valid <= rd_done || wq_pop || wr_byp;
      bus_addr  <= '0;
      bus_rmask <= '0;
      bus_wmask <= '0;
      bus_rdata <= '0;
      bus_wdata <= '0;
      if (rd_done) begin
        bus_addr  <= rd_addr & ~32'h3;
        bus_rmask <= 4'hF;
        bus_rdata <= dmem_rdata;
      end else if (wq_pop) begin
        bus_addr  <= wq_addr[wq_rp[AW-1:0]] & ~32'h3;
        bus_wmask <= wq_strb[wq_rp[AW-1:0]];
        bus_wdata <= wq_data[wq_rp[AW-1:0]];
      end else if (wr_byp) begin
        bus_addr  <= dmem_waddr & ~32'h3;
        bus_wmask <= dmem_wstrb;
        bus_wdata <= dmem_wdata;
      end
      err_overflow <= err_overflow | rd_ovf | wr_ovf;
      err_protocol <= err_protocol | rd_proto;
    end
  end

  assign bus_insn = 1'b0;
endmodule

// File: tb/tb_svc_rv_dbus_mon.sv
// Bench for svc_rv_dbus_mon: SRAM and BRAM instances against a
// queue-based reference model, plus directed scenarios.
module tb_svc_rv_dbus_mon;
  localparam int QD = 2;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] rd;
    logic [31:0] wd;
  } ev_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ren    [2];
  logic [31:0] raddr  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        we     [2];
  logic [31:0] waddr  [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];

  logic        bv     [2];
  logic        binsn  [2];
  logic [31:0] baddr  [2];
  logic [3:0]  brmask [2];
  logic [3:0]  bwmask [2];
  logic [31:0] brdata [2];
  logic [31:0] bwdata [2];
  logic        bovf   [2];
  logic        bproto [2];

  int total = 0;
  int bad = 0;

  ev_t         exp_ev [2];
  logic [1:0]  exp_fl [2];
  logic [31:0] m_pq   [2][$];
  wr_t         m_wq   [2][$];

  always #5 clock = ~clock;

  svc_rv_dbus_mon #(.RD_LAT(0), .QDEPTH(QD)) u_dut0 (
    .clock(clock), .reset(reset),
    .dmem_ren(ren[0]), .dmem_raddr(raddr[0]),
    .dmem_rvalid(rvalid[0]), .dmem_rdata(rdata[0]),
    .dmem_we(we[0]), .dmem_waddr(waddr[0]),
    .dmem_wdata(wdata[0]), .dmem_wstrb(wstrb[0]),
    .bus_valid(bv[0]), .bus_insn(binsn[0]), .bus_addr(baddr[0]),
    .bus_rmask(brmask[0]), .bus_wmask(bwmask[0]),
    .bus_rdata(brdata[0]), .bus_wdata(bwdata[0]),
    .err_overflow(bovf[0]), .err_protocol(bproto[0])
  );

  svc_rv_dbus_mon #(.RD_LAT(1), .QDEPTH(QD)) u_dut1 (
    .clock(clock), .reset(reset),
    .dmem_ren(ren[1]), .dmem_raddr(raddr[1]),
    .dmem_rvalid(rvalid[1]), .dmem_rdata(rdata[1]),
    .dmem_we(we[1]), .dmem_waddr(waddr[1]),
    .dmem_wdata(wdata[1]), .dmem_wstrb(wstrb[1]),
    .bus_valid(bv[1]), .bus_insn(binsn[1]), .bus_addr(baddr[1]),
    .bus_rmask(brmask[1]), .bus_wmask(bwmask[1]),
    .bus_rdata(brdata[1]), .bus_wdata(bwdata[1]),
    .err_overflow(bovf[1]), .err_protocol(bproto[1])
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic ev_t wr_ev(input wr_t w);
    ev_t e;
    e = '0;
    e.v = 1'b1;
    e.a = w.a & ~32'h3;
    e.wm = w.s;
    e.wd = w.d;
    return e;
  endfunction

  function automatic void model_step(input int id);
    ev_t ev;
    wr_t w;
    wr_t o;
    bit hit;
    logic [31:0] ra;
    ev = '0;
    hit = 0;
    ra = '0;
    if (reset) begin
      m_pq[id].delete();
      m_wq[id].delete();
      exp_ev[id] = '0;
      exp_fl[id] = '0;
      return;
    end
    if (id == 0) begin
      hit = ren[0] && rvalid[0];
      ra = raddr[0];
    end else begin
      if (rvalid[1]) begin
        if (m_pq[1].size() == 0) exp_fl[1][0] = 1'b1;
        else begin
          hit = 1;
          ra = m_pq[1].pop_front();
        end
      end
      if (ren[1]) begin
        if (m_pq[1].size() < QD) m_pq[1].push_back(raddr[1]);
        else exp_fl[1][1] = 1'b1;
      end
    end
    w = '{a: waddr[id], d: wdata[id], s: wstrb[id]};
    if (hit) begin
      ev.v = 1'b1;
      ev.a = ra & ~32'h3;
      ev.rm = 4'hF;
      ev.rd = rdata[id];
      if (we[id]) begin
        if (m_wq[id].size() < QD) m_wq[id].push_back(w);
        else exp_fl[id][1] = 1'b1;
      end
    end else if (m_wq[id].size() > 0) begin
      o = m_wq[id].pop_front();
      ev = wr_ev(o);
      if (we[id]) m_wq[id].push_back(w);
    end else if (we[id]) begin
      ev = wr_ev(w);
    end
    exp_ev[id] = ev;
  endfunction

  task automatic cyc();
    ev_t got;
    @(posedge clock);
    model_step(0);
    model_step(1);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      got = '{v: bv[i], a: baddr[i], rm: brmask[i], wm: bwmask[i],
              rd: brdata[i], wd: bwdata[i]};
      chk($sformatf("d%0d_event", i), 128'(got), 128'(exp_ev[i]));
      chk($sformatf("d%0d_flags", i),
          128'({binsn[i], bovf[i], bproto[i]}),
          128'({1'b0, exp_fl[i]}));
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      ren[i] = 0; raddr[i] = '0; rvalid[i] = 0; rdata[i] = '0;
      we[i] = 0; waddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    cyc();
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    cyc();
    cyc();
    chk("reset_state", 128'({bv[0], baddr[0], bovf[0], bproto[0],
                              bv[1], baddr[1], bovf[1], bproto[1]}),
        128'(0));
    reset = 0;

    // SRAM read, unaligned address
    ren[0] = 1; raddr[0] = 32'h103; rvalid[0] = 1;
    rdata[0] = 32'hDEADBEEF;
    cyc();
    chk("sram_read", 128'({bv[0], baddr[0], brmask[0], brdata[0]}),
        128'({1'b1, 32'h100, 4'hF, 32'hDEADBEEF}));
    idle();
    cyc();
    chk("one_cycle_only", 128'(bv[0]), 128'(0));

    // BRAM back-to-back reads
    ren[1] = 1; raddr[1] = 32'h10;
    cyc();
    raddr[1] = 32'h20; rvalid[1] = 1; rdata[1] = 32'hAAAA0001;
    cyc();
    chk("bram_rd0", 128'({bv[1], baddr[1], brdata[1]}),
        128'({1'b1, 32'h10, 32'hAAAA0001}));
    ren[1] = 0; rdata[1] = 32'hAAAA0002;
    cyc();
    chk("bram_rd1", 128'({bv[1], baddr[1], brdata[1]}),
        128'({1'b1, 32'h20, 32'hAAAA0002}));
    idle();
    cyc();

    // read and write in the same cycle
    ren[0] = 1; raddr[0] = 32'h80; rvalid[0] = 1; rdata[0] = 32'h5555;
    we[0] = 1; waddr[0] = 32'h40; wstrb[0] = 4'h3; wdata[0] = 32'h1234;
    cyc();
    chk("rw_read", 128'({bv[0], baddr[0], brmask[0], bwmask[0]}),
        128'({1'b1, 32'h80, 4'hF, 4'h0}));
    idle();
    cyc();
    chk("rw_write", 128'({bv[0], baddr[0], brmask[0], bwmask[0],
                           bwdata[0]}),
        128'({1'b1, 32'h40, 4'h0, 4'h3, 32'h1234}));

    // write-queue overflow
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ren[0] = 1; raddr[0] = 32'h200; rvalid[0] = 1;
      we[0] = 1; waddr[0] = 32'h100 + 32'(4 * k);
      wstrb[0] = 4'hF; wdata[0] = 32'(k + 1);
      cyc();
    end
    idle();
    cyc();
    chk("ovf_w0", 128'({bv[0], baddr[0], bwdata[0]}),
        128'({1'b1, 32'h100, 32'h1}));
    cyc();
    chk("ovf_w1", 128'({bv[0], baddr[0], bwdata[0]}),
        128'({1'b1, 32'h104, 32'h2}));
    cyc();
    chk("ovf_drop", 128'({bv[0], bovf[0]}), 128'({1'b0, 1'b1}));

    // protocol error
    rvalid[1] = 1; rdata[1] = 32'hBAD;
    cyc();
    chk("proto", 128'({bv[1], bproto[1]}), 128'({1'b0, 1'b1}));
    idle();

    // reset with pending read and queued writes
    ren[1] = 1; raddr[1] = 32'h300;
    ren[0] = 1; rvalid[0] = 1; we[0] = 1; waddr[0] = 32'h44;
    cyc();
    ren[1] = 0;
    waddr[0] = 32'h48;
    cyc();
    reset = 1;
    cyc();
    idle();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      rvalid[1] = (k == 0);
      cyc();
      chk("post_reset", 128'({bv[0], bv[1], bovf[0], bovf[1]}),
          128'(0));
    end
    idle();
    do_reset();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        ren[i] = 1'($urandom_range(0, 1));
        raddr[i] = $urandom;
        rdata[i] = $urandom;
        we[i] = ($urandom_range(0, 2) != 0);
        waddr[i] = $urandom;
        wdata[i] = $urandom;
        wstrb[i] = 4'($urandom);
      end
      rvalid[0] = 1'($urandom_range(0, 1));
      if (m_pq[1].size() > 0) rvalid[1] = 1'($urandom_range(0, 1));
      else rvalid[1] = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
